// File: rtl/theremin_filter_pkg.sv
// theremin_filter_pkg: shared types and helpers for the multichannel IIR period filter
// Optional rounding is enabled by THEREMIN_IIR_ROUNDING_EN (see iir_pow2_stage_alu).
package theremin_filter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, COMMIT} filter_state_t;

    // Wide enough for the 16-channel / 16-stage upper limits.
    typedef logic [3:0] ch_idx_t;
    typedef logic [3:0] st_idx_t;

    function automatic logic [63:0] extend_period(input logic [63:0] period, input int shift);
        return period << shift;
    endfunction

    function automatic int round_bias(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

endpackage

// File: rtl/theremin_multichannel_iir_period_filter_alu.sv
// iir_pow2_stage_alu: combinational single IIR stage, next = state + ((src - state) >>> k)
// THEREMIN_IIR_ROUNDING_EN adds half an LSB of the shifted result before the shift.
module iir_pow2_stage_alu
    import theremin_filter_pkg::*;
#(
    parameter int DATA_BITS         = 28,
    parameter int FILTER_SHIFT_BITS = 8
) (
    input  logic [DATA_BITS-1:0] state,
    input  logic [DATA_BITS-1:0] src,
    output logic [DATA_BITS-1:0] next
);

`ifdef THEREMIN_IIR_ROUNDING_EN
    localparam logic signed [DATA_BITS+1:0] BIAS = (DATA_BITS+2)'(round_bias(FILTER_SHIFT_BITS));
`else
    localparam logic signed [DATA_BITS+1:0] BIAS = '0;
`endif

    // Two guard bits keep the biased difference from wrapping.
    logic signed [DATA_BITS+1:0] diff;
    logic signed [DATA_BITS+1:0] step;

    assign diff = $signed({2'b00, src}) - $signed({2'b00, state}) + BIAS;
    assign step = diff >>> FILTER_SHIFT_BITS;
    assign next = state + step[DATA_BITS-1:0];

endmodule

// File: rtl/theremin_multichannel_iir_period_filter.sv
// theremin_multichannel_iir_period_filter: time-multiplexed cascaded IIR smoothing of N period channels
// Optional round-half-up stage arithmetic via THEREMIN_IIR_ROUNDING_EN.
module theremin_multichannel_iir_period_filter
    import theremin_filter_pkg::*;
#(
    parameter int CHANNELS          = 4,
    parameter int PERIOD_BITS       = 16,
    parameter int DATA_BITS         = 28,
    parameter int FILTER_SHIFT_BITS = 8,
    parameter int MAX_STAGES        = 4,
    localparam int SW = (MAX_STAGES > 1) ? $clog2(MAX_STAGES) : 1,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int IW = (CHANNELS * MAX_STAGES > 1) ? $clog2(CHANNELS * MAX_STAGES) : 1
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            SAMPLE_STROBE,
    input  logic [CHANNELS*PERIOD_BITS-1:0] PERIOD_IN,
    input  logic [CHANNELS-1:0]             CHANGE_FLAG_IN,
    input  logic [SW-1:0]                   MAX_STAGE,
    output logic [CHANNELS*DATA_BITS-1:0]   PERIOD_FILTERED,
    output logic [CHANNELS-1:0]             OUT_VALID,
    output logic                            BUSY,
    output logic                            OVERRUN
);

    filter_state_t fsm, fsm_next;
    ch_idx_t ch;
    st_idx_t st, last_st;
    logic [DATA_BITS-1:0] stage_q [CHANNELS*MAX_STAGES];
    logic [DATA_BITS-1:0] held [CHANNELS];
    logic [CHANNELS-1:0] primed;
    logic [IW-1:0] idx;
    logic [DATA_BITS-1:0] alu_src, alu_next;
    st_idx_t clamped;

    assign clamped = (int'(MAX_STAGE) >= MAX_STAGES) ? st_idx_t'(MAX_STAGES - 1) : st_idx_t'(MAX_STAGE);
    assign idx = IW'(int'(ch) * MAX_STAGES + int'(st));
    assign alu_src = (st == '0) ? held[ch[CW-1:0]] : stage_q[idx - IW'(1)];

    iir_pow2_stage_alu #(
        .DATA_BITS(DATA_BITS),
        .FILTER_SHIFT_BITS(FILTER_SHIFT_BITS)
    ) u_alu (
        .state(stage_q[idx]),
        .src(alu_src),
        .next(alu_next)
    );

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    fsm_next = SAMPLE_STROBE ? RUN : IDLE;
            RUN:     fsm_next = (st == last_st && int'(ch) == CHANNELS - 1) ? COMMIT : RUN;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fsm <= IDLE;
            ch <= '0;
            st <= '0;
            last_st <= '0;
            primed <= '0;
            BUSY <= 1'b0;
            OVERRUN <= 1'b0;
            OUT_VALID <= '0;
            PERIOD_FILTERED <= '0;
            for (int c = 0; c < CHANNELS; c++) held[c] <= '0;
            for (int i = 0; i < CHANNELS*MAX_STAGES; i++) stage_q[i] <= '0;
        end else begin
            fsm <= fsm_next;
            OUT_VALID <= '0;
            if (SAMPLE_STROBE && fsm != IDLE) OVERRUN <= 1'b1;
            case (fsm)
                IDLE: if (SAMPLE_STROBE) begin
                    BUSY <= 1'b1;
                    ch <= '0;
                    st <= '0;
                    last_st <= clamped;
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (CHANGE_FLAG_IN[c]) begin
                            held[c] <= DATA_BITS'(extend_period(64'(PERIOD_IN[c*PERIOD_BITS +: PERIOD_BITS]), DATA_BITS - PERIOD_BITS));
                            // First flagged sample jumps every stage straight to the input.
                            if (!primed[c]) begin
                                primed[c] <= 1'b1;
                                for (int s = 0; s < MAX_STAGES; s++)
                                    stage_q[c*MAX_STAGES + s] <= DATA_BITS'(extend_period(64'(PERIOD_IN[c*PERIOD_BITS +: PERIOD_BITS]), DATA_BITS - PERIOD_BITS));
                            end
                        end
                    end
                end
                RUN: begin
                    if (primed[ch[CW-1:0]]) stage_q[idx] <= alu_next;
                    st <= (st == last_st) ? '0 : st + st_idx_t'(1);
                    ch <= (st == last_st) ? ch + ch_idx_t'(1) : ch;
                end
                default: begin
                    BUSY <= 1'b0;
                    OUT_VALID <= primed;
                    for (int c = 0; c < CHANNELS; c++)
                        PERIOD_FILTERED[c*DATA_BITS +: DATA_BITS] <= stage_q[c*MAX_STAGES + int'(last_st)];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_theremin_multichannel_iir_period_filter.sv
// tb_theremin_multichannel_iir_period_filter: randomized self-checking bench against an arithmetic reference model
module tb_theremin_multichannel_iir_period_filter;

    localparam int C = 2;
    localparam int PB = 16;
    localparam int DB = 20;
    localparam int K = 2;
    localparam int MS = 4;

    logic CLK = 0;
    logic RESET = 1;
    logic SAMPLE_STROBE = 0;
    logic [C*PB-1:0] PERIOD_IN = '0;
    logic [C-1:0] CHANGE_FLAG_IN = '0;
    logic [1:0] MAX_STAGE = 2'd3;
    logic [C*DB-1:0] PERIOD_FILTERED;
    logic [C-1:0] OUT_VALID;
    logic BUSY;
    logic OVERRUN;

    int tests = 0;
    int fails = 0;

    longint m_st [C][MS];
    longint m_held [C];
    bit m_pr [C];
    longint m_out [C];
    logic [C-1:0] m_valid;
    int m_last;

    theremin_multichannel_iir_period_filter #(
        .CHANNELS(C), .PERIOD_BITS(PB), .DATA_BITS(DB),
        .FILTER_SHIFT_BITS(K), .MAX_STAGES(MS)
    ) dut (
        .CLK(CLK), .RESET(RESET), .SAMPLE_STROBE(SAMPLE_STROBE),
        .PERIOD_IN(PERIOD_IN), .CHANGE_FLAG_IN(CHANGE_FLAG_IN), .MAX_STAGE(MAX_STAGE),
        .PERIOD_FILTERED(PERIOD_FILTERED), .OUT_VALID(OUT_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint x);
        longint d = longint'(1) << K;
        return (x >= 0) ? x / d : -((-x + d - 1) / d);
    endfunction

    function automatic longint out_of(input int c);
        return longint'(PERIOD_FILTERED[c*DB +: DB]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            m_held[c] = 0;
            m_pr[c] = 0;
            m_out[c] = 0;
            for (int s = 0; s < MS; s++) m_st[c][s] = 0;
        end
        m_valid = '0;
    endtask

    task automatic model_sample(input logic [PB-1:0] p0, input logic [PB-1:0] p1, input logic [1:0] fl, input int ms);
        longint p [C];
        longint bias;
`ifdef THEREMIN_IIR_ROUNDING_EN
        bias = longint'(1) << (K - 1);
`else
        bias = 0;
`endif
        p[0] = p0;
        p[1] = p1;
        m_last = (ms >= MS) ? MS - 1 : ms;
        for (int c = 0; c < C; c++) begin
            if (fl[c]) begin
                m_held[c] = p[c] * (longint'(1) << (DB - PB));
                if (!m_pr[c]) begin
                    m_pr[c] = 1;
                    for (int s = 0; s < MS; s++) m_st[c][s] = m_held[c];
                end
            end
            if (m_pr[c])
                for (int s = 0; s <= m_last; s++) begin
                    longint src = (s == 0) ? m_held[c] : m_st[c][s-1];
                    m_st[c][s] = m_st[c][s] + floor_div(src - m_st[c][s] + bias);
                end
            m_out[c] = m_st[c][m_last];
            m_valid[c] = m_pr[c];
        end
    endtask

    task automatic finish_and_check(input string tag, input int e0, input logic [C*PB-1:0] overrun_data);
        int e = e0;
        bit done = 0;
        while (!done && e < 100) begin
            @(posedge CLK); #1;
            SAMPLE_STROBE = 0;
            e++;
            if (e == 3 && overrun_data != '0) begin
                PERIOD_IN = overrun_data;
                CHANGE_FLAG_IN = 2'b11;
                SAMPLE_STROBE = 1;
            end
            if (e > 1 && !BUSY) done = 1;
        end
        check({tag, "_latency"}, e, C * (m_last + 1) + 2);
        check({tag, "_valid"}, OUT_VALID, m_valid);
        for (int c = 0; c < C; c++) check($sformatf("%s_out%0d", tag, c), out_of(c), m_out[c]);
        @(posedge CLK); #1;
        check({tag, "_valid_pulse"}, OUT_VALID, 0);
    endtask

    task automatic sample(input string tag, input logic [PB-1:0] p0, input logic [PB-1:0] p1, input logic [1:0] fl, input logic [1:0] ms);
        PERIOD_IN = {p1, p0};
        CHANGE_FLAG_IN = fl;
        MAX_STAGE = ms;
        SAMPLE_STROBE = 1;
        model_sample(p0, p1, fl, int'(ms));
        finish_and_check(tag, 0, '0);
    endtask

    task automatic do_reset();
        RESET = 1;
        @(posedge CLK); #1;
        RESET = 0;
        model_reset();
    endtask

    initial begin
        longint prev;
        model_reset();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 0;
        check("rst_out", PERIOD_FILTERED, 0);
        check("rst_valid", OUT_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_overrun", OVERRUN, 0);

        sample("prime", 16'h1000, 16'h0abc, 2'b01, 2'd3);
        check("prime_lit", out_of(0), 20'h10000);

        sample("step", 16'h2000, 16'h0000, 2'b01, 2'd3);
        check("step_lit", out_of(0), 20'h10100);

        prev = out_of(0);
        for (int i = 0; i < 200; i++) begin
            logic [1:0] fl = {1'($urandom), 1'b0};
            sample("held", 16'($urandom), 16'($urandom), fl, 2'd3);
            if (out_of(0) < prev) check("held_monotonic", out_of(0), prev);
            if (out_of(0) > 20'h20000) check("held_bound", out_of(0), 20'h20000);
            prev = out_of(0);
        end
        check("held_near", (20'h20000 - out_of(0) <= 4 * ((1 << K) - 1)) ? 1 : 0, 1);

        PERIOD_IN = {16'h1234, 16'h3000};
        CHANGE_FLAG_IN = 2'b11;
        MAX_STAGE = 2'd3;
        SAMPLE_STROBE = 1;
        model_sample(16'h3000, 16'h1234, 2'b11, 3);
        finish_and_check("overrun", 0, {16'hffff, 16'hffff});
        check("overrun_flag", OVERRUN, 1);
        sample("after_overrun", 16'($urandom), 16'($urandom), 2'b11, 2'd3);
        check("overrun_sticky", OVERRUN, 1);

        do_reset();
        check("rst2_overrun", OVERRUN, 0);
        sample("depth0_prime", 16'h1000, 16'h0000, 2'b01, 2'd0);
        sample("depth0_step", 16'h2000, 16'h0000, 2'b01, 2'd0);
        check("depth0_lit", out_of(0), 20'h14000);
        sample("depth3_after0", 16'h0000, 16'h4321, 2'b10, 2'd3);
        for (int i = 0; i < 6; i++)
            sample("rand_depth", 16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom));

        PERIOD_IN = {16'h5555, 16'h6666};
        CHANGE_FLAG_IN = 2'b11;
        MAX_STAGE = 2'd3;
        SAMPLE_STROBE = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            SAMPLE_STROBE = 0;
        end
        RESET = 1;
        @(posedge CLK); #1;
        RESET = 0;
        model_reset();
        check("midrun_busy", BUSY, 0);
        check("midrun_out", PERIOD_FILTERED, 0);
        check("midrun_valid", OUT_VALID, 0);
        check("midrun_overrun", OVERRUN, 0);
        sample("reprime_ch1", 16'h7777, 16'h0800, 2'b10, 2'd3);
        check("reprime_ch1_lit", out_of(1), 20'h08000);
        sample("reprime_ch0", 16'h0900, 16'h0000, 2'b01, 2'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
